// File: rtl/ysyx_22051013_lsu_ctrl_if.sv
// Memory request/response bus between the LSU controller and the data memory.
// The LSU is the master: it issues one request at a time with valid/ready.
// The memory answers with a single-cycle response. The master always accepts that response.
interface ysyx_22051013_lsu_ctrl_if #(
    parameter int DATA_W = 64
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [DATA_W-1:0]     mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_resp_rdata;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_wen,
        output mem_req_wdata,
        output mem_req_wmask,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_wen,
        input  mem_req_wdata,
        input  mem_req_wmask,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_rdata
    );
endinterface

// File: rtl/ysyx_22051013_lsu_ctrl.sv
// Load/store unit controller. It takes one instruction at a time from EX/LS.
// For loads and stores it runs one memory transaction on the request bus.
// It then presents the completed result to LS/WB together with the forwarding value.
// Optional macro YSYX_22051013_LSU_MISALIGN_CHK_EN enables the misaligned-access checker.
// A misaligned h/w/d access skips the bus and completes with ls_misalign set.
// When the macro is undefined, ls_misalign stays 0.
module ysyx_22051013_lsu_ctrl #(
    parameter int DATA_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    // upstream (EX/LS register)
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [31:0]          ex_inst,
    input  logic [DATA_W-1:0]    ex_pc,
    input  logic [DATA_W-1:0]    ex_exu_res,
    input  logic [DATA_W-1:0]    ex_store_data,
    input  logic                 ex_mem_rd,
    input  logic                 ex_mem_wr,
    input  logic [2:0]           ex_mem_size,
    input  logic [1:0]           ex_wbctl,
    input  logic                 ex_rd_ena,
    input  logic [4:0]           ex_rd_addr,
    // memory bus
    ysyx_22051013_lsu_ctrl_if.master mem,
    // downstream (LS/WB register)
    input  logic                 wb_stall,
    output logic                 ls_out_valid,
    output logic [31:0]          ls_inst,
    output logic [DATA_W-1:0]    ls_pc,
    output logic [1:0]           ls_wbctl,
    output logic [DATA_W-1:0]    ls_exu_res,
    output logic                 ls_rd_ena,
    output logic [4:0]           ls_rd_addr,
    output logic [DATA_W-1:0]    ls_wbdata,
    output logic [DATA_W-1:0]    ls_data_forward,
    output logic                 ls_misalign
);
    localparam int MASK_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(MASK_W);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t state_reg, state_next;

    logic [31:0]         ls_inst_reg;
    logic [DATA_W-1:0]   ls_pc_reg;
    logic [1:0]          ls_wbctl_reg;
    logic [DATA_W-1:0]   ls_exu_res_reg;
    logic                ls_rd_ena_reg;
    logic [4:0]          ls_rd_addr_reg;
    logic [DATA_W-1:0]   ls_wbdata_reg;
    logic                misalign_reg;
    logic [DATA_W-1:0]   store_data_reg;
    logic                mem_rd_reg;
    logic                mem_wr_reg;
    logic [2:0]          mem_size_reg;

    logic                accept;
    logic                misaligned_in;
    logic                resp_take;
    logic [OFF_W-1:0]    off;
    logic [MASK_W-1:0]   base_mask;
    logic [DATA_W-1:0]   load_raw;
    logic [DATA_W-1:0]   load_ext;
    logic                in_req;

`ifdef YSYX_22051013_LSU_MISALIGN_CHK_EN
    logic [OFF_W-1:0]    ex_off;
    assign ex_off = ex_exu_res[OFF_W-1:0];

    // Flag an incoming memory op whose natural alignment is violated
    always_comb begin
        misaligned_in = 1'b0;
        if (ex_mem_rd || ex_mem_wr) begin
            case (ex_mem_size[1:0])
                2'b01:   misaligned_in = ex_off[0];
                2'b10:   misaligned_in = |ex_off[1:0];
                2'b11:   misaligned_in = |ex_off;
                default: misaligned_in = 1'b0;
            endcase
        end
    end
`else
    assign misaligned_in = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the upstream ready/accept decision
    always_comb begin
        state_next = state_reg;
        ex_ready   = 1'b0;
        accept     = 1'b0;
        resp_take  = 1'b0;
        case (state_reg)
            IDLE: begin
                ex_ready = !wb_stall;
                accept   = ex_valid && !wb_stall;
                if (accept) begin
                    state_next = ((ex_mem_rd || ex_mem_wr) && !misaligned_in) ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_take = mem.mem_resp_valid;
                if (mem.mem_resp_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ex_ready = !wb_stall;
                accept   = ex_valid && !wb_stall;
                if (!wb_stall) begin
                    if (accept) begin
                        state_next = ((ex_mem_rd || ex_mem_wr) && !misaligned_in) ? REQ : DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte-lane alignment of the store data and mask, and extraction of the load data
    assign off      = ls_exu_res_reg[OFF_W-1:0];
    assign load_raw = mem.mem_resp_rdata >> {off, 3'b000};

    // Base byte mask for the access size; unsigned loads share the signed sizes
    always_comb begin
        case (mem_size_reg[1:0])
            2'b00:   base_mask = MASK_W'(8'h01);
            2'b01:   base_mask = MASK_W'(8'h03);
            2'b10:   base_mask = MASK_W'(8'h0F);
            default: base_mask = '1;
        endcase
    end

    // Sign- or zero-extend the shifted load word by funct3
    always_comb begin
        case (mem_size_reg)
            3'b000:  load_ext = {{(DATA_W-8){load_raw[7]}},   load_raw[7:0]};
            3'b001:  load_ext = {{(DATA_W-16){load_raw[15]}}, load_raw[15:0]};
            3'b010:  load_ext = {{(DATA_W-32){load_raw[31]}}, load_raw[31:0]};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}},          load_raw[7:0]};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}},         load_raw[15:0]};
            3'b110:  load_ext = {{(DATA_W-32){1'b0}},         load_raw[31:0]};
            default: load_ext = load_raw;
        endcase
    end

    // Request outputs are driven only while a request is pending, else held at 0
    assign in_req             = (state_reg == REQ);
    assign mem.mem_req_valid  = in_req;
    assign mem.mem_req_addr   = in_req ? {ls_exu_res_reg[DATA_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem.mem_req_wen    = in_req && mem_wr_reg;
    assign mem.mem_req_wdata  = in_req ? (store_data_reg << {off, 3'b000}) : '0;
    assign mem.mem_req_wmask  = in_req ? (base_mask << off) : '0;

    // Latch the instruction on accept and capture load data when the response arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            ls_inst_reg    <= '0;
            ls_pc_reg      <= '0;
            ls_wbctl_reg   <= '0;
            ls_exu_res_reg <= '0;
            ls_rd_ena_reg  <= 1'b0;
            ls_rd_addr_reg <= '0;
            ls_wbdata_reg  <= '0;
            misalign_reg   <= 1'b0;
            store_data_reg <= '0;
            mem_rd_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
            mem_size_reg   <= '0;
        end else begin
            if (accept) begin
                ls_inst_reg    <= ex_inst;
                ls_pc_reg      <= ex_pc;
                ls_wbctl_reg   <= ex_wbctl;
                ls_exu_res_reg <= ex_exu_res;
                ls_rd_ena_reg  <= ex_rd_ena && !ex_mem_wr && !misaligned_in;
                ls_rd_addr_reg <= ex_rd_addr;
                ls_wbdata_reg  <= '0;
                misalign_reg   <= misaligned_in;
                store_data_reg <= ex_store_data;
                mem_rd_reg     <= ex_mem_rd;
                mem_wr_reg     <= ex_mem_wr;
                mem_size_reg   <= ex_mem_size;
            end else if (state_reg == DONE && !wb_stall) begin
                misalign_reg   <= 1'b0;
            end
            if (resp_take && mem_rd_reg) begin
                ls_wbdata_reg  <= load_ext;
            end
        end
    end

    assign ls_out_valid    = (state_reg == DONE);
    assign ls_inst         = ls_inst_reg;
    assign ls_pc           = ls_pc_reg;
    assign ls_wbctl        = ls_wbctl_reg;
    assign ls_exu_res      = ls_exu_res_reg;
    assign ls_rd_ena       = ls_rd_ena_reg;
    assign ls_rd_addr      = ls_rd_addr_reg;
    assign ls_wbdata       = ls_wbdata_reg;
    assign ls_data_forward = mem_rd_reg ? ls_wbdata_reg : ls_exu_res_reg;
    assign ls_misalign     = misalign_reg;
endmodule

// File: tb/tb_ysyx_22051013_lsu_ctrl.sv
// Testbench for ysyx_22051013_lsu_ctrl.
// It applies a table of directed instructions, each with hand-computed bus and result values.
// Hand-written sequences cover reset during a response, wb_stall back-to-back behaviour, and the misaligned word load.
module tb_ysyx_22051013_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_inst;
    logic [63:0] ex_pc;
    logic [63:0] ex_exu_res;
    logic [63:0] ex_store_data;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [2:0]  ex_mem_size;
    logic [1:0]  ex_wbctl;
    logic        ex_rd_ena;
    logic [4:0]  ex_rd_addr;
    logic        wb_stall;
    logic        ls_out_valid;
    logic [31:0] ls_inst;
    logic [63:0] ls_pc;
    logic [1:0]  ls_wbctl;
    logic [63:0] ls_exu_res;
    logic        ls_rd_ena;
    logic [4:0]  ls_rd_addr;
    logic [63:0] ls_wbdata;
    logic [63:0] ls_data_forward;
    logic        ls_misalign;

    ysyx_22051013_lsu_ctrl_if #(.DATA_W(64)) mem_bus ();

    ysyx_22051013_lsu_ctrl #(.DATA_W(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_inst         (ex_inst),
        .ex_pc           (ex_pc),
        .ex_exu_res      (ex_exu_res),
        .ex_store_data   (ex_store_data),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_wr       (ex_mem_wr),
        .ex_mem_size     (ex_mem_size),
        .ex_wbctl        (ex_wbctl),
        .ex_rd_ena       (ex_rd_ena),
        .ex_rd_addr      (ex_rd_addr),
        .mem             (mem_bus),
        .wb_stall        (wb_stall),
        .ls_out_valid    (ls_out_valid),
        .ls_inst         (ls_inst),
        .ls_pc           (ls_pc),
        .ls_wbctl        (ls_wbctl),
        .ls_exu_res      (ls_exu_res),
        .ls_rd_ena       (ls_rd_ena),
        .ls_rd_addr      (ls_rd_addr),
        .ls_wbdata       (ls_wbdata),
        .ls_data_forward (ls_data_forward),
        .ls_misalign     (ls_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] exu;
        logic [63:0] sdata;
        logic        rd;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  wbctl;
        logic        rd_ena;
        logic [4:0]  rd_addr;
        logic [63:0] rdata;
        int          delay;
        logic        req;
        logic [63:0] e_addr;
        logic        e_wen;
        logic [63:0] e_wdata;
        logic [7:0]  e_wmask;
        logic [63:0] e_wbdata;
        logic [63:0] e_fwd;
        logic        e_rd_ena;
        logic        e_mis;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;
    int cur = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %h expected %h", cur, name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] inst, input logic [63:0] exu,
                                 input logic [63:0] sdata, input logic rd, input logic wr,
                                 input logic [2:0] size, input logic rd_ena,
                                 input logic [63:0] rdata, input int delay,
                                 input logic [63:0] e_addr, input logic [7:0] e_wmask,
                                 input logic [63:0] e_wdata, input logic [63:0] e_wbdata,
                                 input logic [63:0] e_fwd, input logic e_rd_ena);
        vec_t v;
        v.inst = inst; v.exu = exu; v.sdata = sdata; v.rd = rd; v.wr = wr;
        v.size = size; v.rd_ena = rd_ena; v.rdata = rdata; v.delay = delay;
        v.pc = 64'h0; v.wbctl = 2'b00; v.rd_addr = 5'd0;
        v.req = rd | wr; v.e_addr = e_addr; v.e_wen = wr; v.e_wdata = e_wdata;
        v.e_wmask = e_wmask; v.e_wbdata = e_wbdata; v.e_fwd = e_fwd;
        v.e_rd_ena = e_rd_ena; v.e_mis = 1'b0;
        return v;
    endfunction

    task automatic drive_ex(input vec_t v);
        ex_inst       = v.inst;
        ex_pc         = v.pc;
        ex_exu_res    = v.exu;
        ex_store_data = v.sdata;
        ex_mem_rd     = v.rd;
        ex_mem_wr     = v.wr;
        ex_mem_size   = v.size;
        ex_wbctl      = v.wbctl;
        ex_rd_ena     = v.rd_ena;
        ex_rd_addr    = v.rd_addr;
    endtask

    // One complete instruction: accept, optional bus transaction with a modelled memory, result check
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive_ex(v);
        ex_valid = 1'b1;
        chk("ex_ready", ex_ready, 1'b1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (v.req) begin
            for (int c = 0; c <= v.delay; c++) begin
                @(negedge clk);
                chk("req_valid", mem_bus.mem_req_valid, 1'b1);
                chk("req_addr",  mem_bus.mem_req_addr,  v.e_addr);
                chk("req_wen",   mem_bus.mem_req_wen,   v.e_wen);
                chk("req_wdata", mem_bus.mem_req_wdata, v.e_wdata);
                chk("req_wmask", mem_bus.mem_req_wmask, v.e_wmask);
                if (c == v.delay) mem_bus.mem_req_ready = 1'b1;
                @(posedge clk); #1;
            end
            mem_bus.mem_req_ready = 1'b0;
            @(negedge clk);
            chk("resp_req_valid", mem_bus.mem_req_valid, 1'b0);
            chk("resp_out_valid", ls_out_valid, 1'b0);
            mem_bus.mem_resp_valid = 1'b1;
            mem_bus.mem_resp_rdata = v.rdata;
            @(posedge clk); #1;
            mem_bus.mem_resp_valid = 1'b0;
            mem_bus.mem_resp_rdata = 64'h0;
        end
        @(negedge clk);
        chk("out_valid",   ls_out_valid, 1'b1);
        chk("done_reqv",   mem_bus.mem_req_valid, 1'b0);
        chk("ls_inst",     ls_inst, v.inst);
        chk("ls_pc",       ls_pc, v.pc);
        chk("ls_wbctl",    ls_wbctl, v.wbctl);
        chk("ls_exu_res",  ls_exu_res, v.exu);
        chk("ls_rd_ena",   ls_rd_ena, v.e_rd_ena);
        chk("ls_rd_addr",  ls_rd_addr, v.rd_addr);
        chk("ls_wbdata",   ls_wbdata, v.e_wbdata);
        chk("ls_forward",  ls_data_forward, v.e_fwd);
        chk("ls_misalign", ls_misalign, v.e_mis);
        $display("vec%0d inst=%h addr=%h wbdata=%h fwd=%h errors=%0d", cur, v.inst, v.exu, ls_wbdata, ls_data_forward, errors);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t a, b;
        //          inst          exu                     sdata                  rd wr size   rde rdata                  dly e_addr                 wmask  e_wdata                e_wbdata               e_fwd                  e_rde
        vecs[0]  = mkv(32'h00a00293, 64'h1234_5678_9abc_def0, 64'h0,                0, 0, 3'b000, 1, 64'h0,                 0, 64'h0,                 8'h00, 64'h0,                 64'h0,                 64'h1234_5678_9abc_def0, 1);
        vecs[1]  = mkv(32'h00300083, 64'h1003,                64'h0,                1, 0, 3'b000, 1, 64'h0000_0000_8000_0000, 0, 64'h1000,            8'h08, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 1);
        vecs[2]  = mkv(32'h00304083, 64'h1003,                64'h0,                1, 0, 3'b100, 1, 64'h0000_0000_8000_0000, 0, 64'h1000,            8'h08, 64'h0,                 64'h80,                64'h80,                1);
        vecs[3]  = mkv(32'h00209323, 64'h2006,                64'h1234,             0, 1, 3'b001, 1, 64'h0,                 4, 64'h2000,              8'hC0, 64'h1234_0000_0000_0000, 64'h0,               64'h2006,              0);
        vecs[4]  = mkv(32'h00003083, 64'h4000,                64'h0,                1, 0, 3'b011, 1, 64'hDEAD_BEEF_0123_4567, 0, 64'h4000,            8'hFF, 64'h0,                 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1);
        vecs[5]  = mkv(32'h00402083, 64'h5004,                64'h0,                1, 0, 3'b010, 1, 64'h8765_4321_0000_0000, 1, 64'h5000,            8'hF0, 64'h0,                 64'hFFFF_FFFF_8765_4321, 64'hFFFF_FFFF_8765_4321, 1);
        vecs[6]  = mkv(32'h00205083, 64'h6002,                64'h0,                1, 0, 3'b101, 1, 64'h0000_0000_F00D_0000, 0, 64'h6000,            8'h0C, 64'h0,                 64'h0000_0000_0000_F00D, 64'h0000_0000_0000_F00D, 1);
        vecs[7]  = mkv(32'h00113023, 64'h7000,                64'h1122_3344_5566_7788, 0, 1, 3'b011, 0, 64'h0,              2, 64'h7000,              8'hFF, 64'h1122_3344_5566_7788, 64'h0,               64'h7000,              0);
        vecs[8]  = mkv(32'h00202083, 64'h3002,                64'h0,                1, 0, 3'b010, 1, 64'h0000_CAFE_BABE_0000, 0, 64'h3000,            8'h3C, 64'h0,                 64'hFFFF_FFFF_CAFE_BABE, 64'hFFFF_FFFF_CAFE_BABE, 1);
        vecs[9]  = mkv(32'h00112223, 64'h8004,                64'hAABB_CCDD,        0, 1, 3'b010, 1, 64'h0,                 0, 64'h8000,              8'hF0, 64'hAABB_CCDD_0000_0000, 64'h0,               64'h8004,              0);
        vecs[10] = mkv(32'h00006083, 64'h9000,                64'h0,                1, 0, 3'b110, 1, 64'h0000_0000_8000_0001, 0, 64'h9000,            8'h0F, 64'h0,                 64'h0000_0000_8000_0001, 64'h0000_0000_8000_0001, 1);
        vecs[11] = mkv(32'h00001083, 64'hA000,                64'h0,                1, 0, 3'b001, 1, 64'h0000_0000_0000_8001, 0, 64'hA000,            8'h03, 64'h0,                 64'hFFFF_FFFF_FFFF_8001, 64'hFFFF_FFFF_FFFF_8001, 1);
`ifdef YSYX_22051013_LSU_MISALIGN_CHK_EN
        vecs[8].req      = 1'b0;
        vecs[8].e_wbdata = 64'h0;
        vecs[8].e_fwd    = 64'h0;
        vecs[8].e_rd_ena = 1'b0;
        vecs[8].e_mis    = 1'b1;
`endif
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].pc      = 64'h8000_0000 + 64'(i * 4);
            vecs[i].wbctl   = 2'(i);
            vecs[i].rd_addr = 5'(i + 1);
        end

        rst = 1'b1; ex_valid = 1'b0; wb_stall = 1'b0;
        ex_inst = '0; ex_pc = '0; ex_exu_res = '0; ex_store_data = '0;
        ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_mem_size = '0; ex_wbctl = '0;
        ex_rd_ena = 1'b0; ex_rd_addr = '0;
        mem_bus.mem_req_ready = 1'b0; mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        cur = -1;
        @(negedge clk);
        chk("rst_ex_ready",  ex_ready, 1'b1);
        chk("rst_out_valid", ls_out_valid, 1'b0);
        chk("rst_req_valid", mem_bus.mem_req_valid, 1'b0);
        chk("rst_wmask",     mem_bus.mem_req_wmask, 8'h00);
        chk("rst_wbdata",    ls_wbdata, 64'h0);
        chk("rst_forward",   ls_data_forward, 64'h0);
        chk("rst_misalign",  ls_misalign, 1'b0);
        wb_stall = 1'b1;
        #1 chk("rst_ex_ready_stall", ex_ready, 1'b0);
        wb_stall = 1'b0;
        $display("reset state errors=%0d", errors);

        for (int i = 0; i < NVEC; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // Reset while awaiting a response; the late response must be dropped
        cur = 100;
        a = vecs[4];
        @(negedge clk);
        drive_ex(a); ex_valid = 1'b1;
        @(posedge clk); #1 ex_valid = 1'b0;
        @(negedge clk);
        chk("mr_req_valid", mem_bus.mem_req_valid, 1'b1);
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk); #1 mem_bus.mem_req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_out_valid", ls_out_valid, 1'b0);
        chk("mr_req_valid0", mem_bus.mem_req_valid, 1'b0);
        mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk); #1 mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_resp_rdata = '0;
        @(negedge clk);
        chk("mr_late_out_valid", ls_out_valid, 1'b0);
        chk("mr_late_wbdata", ls_wbdata, 64'h0);
        chk("mr_ex_ready", ex_ready, 1'b1);
        $display("reset mid-RESP errors=%0d", errors);

        // Two ALU ops back-to-back with wb_stall held for two cycles in DONE
        cur = 101;
        a = vecs[0];
        b = vecs[0];
        b.exu = 64'h0BAD_F00D_0000_0042; b.rd_addr = 5'd17; b.inst = 32'h04200893;
        @(negedge clk);
        drive_ex(a); ex_valid = 1'b1;
        @(posedge clk); #1;
        drive_ex(b); wb_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("st_out_valid", ls_out_valid, 1'b1);
            chk("st_ex_ready",  ex_ready, 1'b0);
            chk("st_exu_frozen", ls_exu_res, a.exu);
            chk("st_rd_frozen", ls_rd_addr, a.rd_addr);
            @(posedge clk); #1;
        end
        wb_stall = 1'b0;
        @(negedge clk);
        chk("st_rel_ex_ready", ex_ready, 1'b1);
        chk("st_rel_exu", ls_exu_res, a.exu);
        @(posedge clk); #1 ex_valid = 1'b0;
        @(negedge clk);
        chk("st_second_valid", ls_out_valid, 1'b1);
        chk("st_second_exu", ls_exu_res, b.exu);
        chk("st_second_rd", ls_rd_addr, b.rd_addr);
        chk("st_second_inst", ls_inst, b.inst);
        @(posedge clk); #1;
        @(negedge clk);
        chk("st_idle_valid", ls_out_valid, 1'b0);
        $display("back-to-back stall errors=%0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22051013_lsu_ctrl.md
# ysyx_22051013_lsu_ctrl

Load/store unit controller for the pipelined CPU: accepts one instruction at a time from the EX/LS register, runs its memory access over a valid/ready request bus, then presents the completed result to the LS/WB pipeline register. It formats store data and byte masks, sign- or zero-extends load data, and drives the LS-stage forwarding value. Handshakes: ex_valid/ex_ready upstream, wb_stall/ls_out_valid downstream.

## Interface
- DATA_W, 64, data/address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX/LS holds a valid instruction
- ex_ready  out  1  LSU accepts the instruction this cycle
- ex_inst  in  32  instruction word
- ex_pc  in  64  PC
- ex_exu_res  in  64  ALU result (effective address for memory ops)
- ex_store_data  in  64  rs2 value for stores
- ex_mem_rd / ex_mem_wr  in  1/1  load / store (never both)
- ex_mem_size  in  3  funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- ex_wbctl  in  2  writeback select, passed through
- ex_rd_ena, ex_rd_addr  in  1, 5  destination register
- mem_req_valid / mem_req_ready  out/in  1/1  request handshake
- mem_req_addr  out  64  {ex_exu_res[63:3], 3'b0}
- mem_req_wen  out  1  1 = write
- mem_req_wdata  out  64  shifted store data
- mem_req_wmask  out  8  byte enables
- mem_resp_valid  in  1  read data / write ack; always accepted
- mem_resp_rdata  in  64  aligned doubleword
- wb_stall  in  1  downstream holding; LSU must hold outputs
- ls_out_valid  out  1  ls_* carry a completed instruction; when 0, LS/WB loads a bubble
- ls_inst, ls_pc, ls_wbctl, ls_exu_res, ls_rd_ena, ls_rd_addr  out  as inputs  registered copies
- ls_wbdata  out  64  extended load data (0 for non-loads)
- ls_data_forward  out  64  ls_wbdata for loads, else ls_exu_res
- ls_misalign  out  1  misaligned access (only with checker macro)

## Operation
- States: IDLE, REQ, RESP, DONE. Reset: IDLE, every output 0, ex_ready = !wb_stall.
- ex_ready = !wb_stall && (IDLE || DONE). Accept = ex_valid && ex_ready; fields latched on accept.
- Accept of non-memory op -> DONE. Accept of load/store -> REQ.
- REQ: mem_req_valid = 1, addr/wen/wdata/wmask stable; on mem_req_ready -> RESP.
- RESP: on mem_resp_valid -> DONE; load data extracted and extended in that cycle, stored into ls_wbdata.
- DONE: ls_out_valid = 1. If wb_stall: stay, outputs frozen. Else accept next (-> DONE/REQ) or -> IDLE.
- Offset o = addr[2:0]. Store: wdata = store_data << 8*o; wmask = {01,03,0F,FF}[size] << o (masked to 8 bits).
- Load: r = rdata >> 8*o, then b/h/w sign-extended, bu/hu/wu zero-extended, d unchanged.
- mem_resp_valid outside RESP is ignored. ls_rd_ena forced 0 for stores.

## Timing
- Non-memory op accepted in cycle T: ls_out_valid at T+1.
- Memory op accepted at T: mem_req_valid from T+1; ready at H; response at R >= H+1; ls_out_valid at R+1. Zero-wait minimum: T+3.
- Back-to-back: accept in DONE cycle when !wb_stall; ls_* update next edge with no bubble.
- rst at any state (incl. REQ with request pending, RESP awaiting response): IDLE next edge, mem_req_valid 0; late responses dropped.
- wb_stall during REQ/RESP does not stall the bus transaction; only DONE exit and acceptance wait.

## Configuration
- YSYX_22051013_LSU_MISALIGN_CHK_EN defined: h with o[0]!=0, w with o[1:0]!=0, d with o!=0 skip REQ/RESP, go directly to DONE with ls_misalign=1, ls_rd_ena=0, no bus request; ls_misalign cleared on DONE exit.
- Undefined: no check, ls_misalign tied 0; access issued, bytes beyond the doubleword dropped by mask/shift truncation.

## Test plan
- Reset mid-RESP: rst one cycle -> IDLE, ls_out_valid=0, mem_req_valid=0; response next cycle ignored.
- lb at 0x1003, rdata=0x0000_0000_8000_0000 -> wmask unused, ls_wbdata=0xFFFF_FFFF_FFFF_FF80; lbu same -> 0x80.
- sh at 0x2006, store_data=0x1234 -> addr 0x2000, wmask=0xC0, wdata=0x1234_0000_0000_0000, ls_rd_ena=0.
- mem_req_ready low 4 cycles -> mem_req_valid held, addr/wdata stable; ls_out_valid 1 cycle after response.
- Two ALU ops back-to-back, wb_stall high 2 cycles in DONE -> ls_* frozen, ex_ready=0; second op appears one cycle after stall release.
- Macro on, lw at 0x3002 -> no mem_req_valid, ls_misalign=1 at T+1; macro off -> request with wmask=0x3C.
